boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, program-memory word-address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000, maximum idle gap between words inside a LOAD transaction.
REQ-003 clk  input  1  system clock; all flops rise on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_word  input  32  received word from the UART word adapter.
REQ-006 rx_valid  input  1  one-cycle pulse; rx_word is valid in that cycle.
REQ-007 tx_word  output  32  word to transmit.
REQ-008 tx_req  output  1  transmit request, level.
REQ-009 tx_done  input  1  one-cycle pulse; word transmission complete.
REQ-010 mem_addr  output  ADDR_W  program-memory write address.
REQ-011 mem_wdata  output  32  program-memory write data.
REQ-012 mem_we  output  1  one-cycle write strobe.
REQ-013 core_run  output  1  1 = CPU released from reset, 0 = CPU held.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_timeout  output  1  one-cycle pulse on LOAD timeout.

Function
REQ-016 The block SHALL implement states IDLE, GET_ADDR, GET_LEN, GET_DATA and SEND.
REQ-017 In IDLE, a word with rx_word[31:16] != 16'hB007 SHALL be dropped silently, with no response.
REQ-018 Command words SHALL be:
- 0xB007_0001: LOAD
- 0xB007_0002: RUN
- 0xB007_0003: HALT
- any other 0xB007_xxxx: NACK 0xBAD0_0001.
REQ-019 RUN SHALL set core_run=1 and send ACK 0xACED_0002.
REQ-020 HALT SHALL set core_run=0 and send ACK 0xACED_0003.
REQ-021 LOAD with core_run=1 SHALL send NACK 0xBAD0_0003 and stay out of GET_ADDR.
REQ-022 LOAD with core_run=0 SHALL go to GET_ADDR.
REQ-023 GET_ADDR:
- the next word's [ADDR_W-1:0] is the base address; upper bits are ignored
- transition to GET_LEN.
REQ-024 GET_LEN: the next word is length N.
- If N==0, or base+N > 2**ADDR_W (computed 33-bit wide), send NACK 0xBAD0_0002.
- Otherwise clear the checksum and the index and go to GET_DATA.
REQ-025 GET_DATA, for each rx_valid at cycle t:
- in cycle t+1: mem_we=1, mem_addr=base+index, mem_wdata=word
- checksum += word, modulo 2**32
- index increments.
REQ-026 After the Nth data word, the block SHALL go to SEND with tx_word = final checksum.
REQ-027 mem_we SHALL be asserted only in GET_DATA write cycles.
REQ-028 mem_addr and mem_wdata SHALL hold their last values otherwise.
REQ-029 SEND:
- tx_req=1 and tx_word stable until the tx_done pulse
- tx_req deasserts in the cycle after tx_done
- then return to IDLE.
REQ-030 rx_valid arriving during SEND, including in the same cycle as tx_done, SHALL be dropped.
REQ-031 In GET_ADDR/GET_LEN/GET_DATA, a timeout counter SHALL:
- reset on each rx_valid
- on reaching TIMEOUT_CYCLES, pulse err_timeout for 1 cycle and return to IDLE, with no transmission
- leave memory already written unchanged.
REQ-032 Response latency: tx_req SHALL rise in the cycle after the rx_valid that completes a command, the last data word, or an invalid length.
REQ-033 core_run SHALL change only on RUN/HALT acceptance or reset.

Reset
REQ-034 Asserting rst, including mid-LOAD or mid-SEND, SHALL immediately force:
- state=IDLE
- tx_req=0, tx_word=0
- mem_we=0, mem_addr=0, mem_wdata=0
- core_run=0, busy=0, err_timeout=0
- checksum=0, index=0, timeout counter=0.
REQ-035 After rst deasserts, the first accepted word SHALL be treated as a command candidate.

Verification
REQ-036 LOAD, base 0x010, N=3, data 0x1,0x2,0xFFFF_FFFF -> writes at 0x010..0x012, then tx_word=0x0000_0002 with tx_req held until tx_done.
REQ-037 LOAD, base 0x3FE, N=3 (ADDR_W=10) -> NACK 0xBAD0_0002, no mem_we; separately, N=0 -> same NACK.
REQ-038 RUN -> core_run=1, ACK 0xACED_0002; then LOAD -> NACK 0xBAD0_0003; HALT -> core_run=0, ACK 0xACED_0003.
REQ-039 Garbage 0x1234_5678 in IDLE -> no response, busy stays 0; 0xB007_00FF -> NACK 0xBAD0_0001.
REQ-040 LOAD, base, N=4, 2 data words, then silence (TIMEOUT_CYCLES=100) -> err_timeout pulse at gap 100, IDLE, exactly 2 writes.
REQ-041 rst pulse during GET_DATA and during SEND -> all outputs at reset values next cycle; a following RUN is accepted normally.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - word-oriented boot loader: command decode, program-memory load with checksum, CPU run/halt control
module boot_loader_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rx_word,
  input  logic              rx_valid,
  output logic [31:0]       tx_word,
  output logic              tx_req,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              core_run,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [15:0] CMD_TAG   = 16'hB007;
  localparam logic [31:0] ACK_RUN   = 32'hACED_0002;
  localparam logic [31:0] ACK_HALT  = 32'hACED_0003;
  localparam logic [31:0] NACK_CMD  = 32'hBAD0_0001;
  localparam logic [31:0] NACK_LEN  = 32'hBAD0_0002;
  localparam logic [31:0] NACK_BUSY = 32'hBAD0_0003;
  localparam logic [32:0] MEM_WORDS = 33'(1) << ADDR_W;
  // The counter only has to reach TIMEOUT_CYCLES-1 before the expiry cycle.
  localparam int          TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_LEN,
    ST_GET_DATA,
    ST_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       tx_word_q, tx_word_d;
  logic              core_run_q, core_run_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [31:0]       csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic              in_load;
  logic              len_bad;
  logic [ADDR_W:0]   idx_inc;
  logic [31:0]       csum_inc;

  assign in_load  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_LEN) ||
                    (state_q == ST_GET_DATA);
  // Length check is done 33 bits wide so a huge N cannot wrap into range.
  assign len_bad  = (rx_word == 32'd0) ||
                    (({1'b0, rx_word} + 33'(base_q)) > MEM_WORDS);
  assign idx_inc  = idx_q + 1'b1;
  assign csum_inc = csum_q + rx_word;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: response word, memory port, load bookkeeping, timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_word_q   <= '0;
      core_run_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      tx_word_q   <= tx_word_d;
      core_run_q  <= core_run_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath updates for command decode, load and response.
  always_comb begin
    state_d     = state_q;
    tx_word_d   = tx_word_q;
    core_run_d  = core_run_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_word[31:16] == CMD_TAG)) begin
          tmo_d = '0;
          case (rx_word[15:0])
            16'h0001: begin
              if (core_run_q) begin
                tx_word_d = NACK_BUSY;
                state_d   = ST_SEND;
              end else begin
                state_d   = ST_GET_ADDR;
              end
            end
            16'h0002: begin
              core_run_d = 1'b1;
              tx_word_d  = ACK_RUN;
              state_d    = ST_SEND;
            end
            16'h0003: begin
              core_run_d = 1'b0;
              tx_word_d  = ACK_HALT;
              state_d    = ST_SEND;
            end
            default: begin
              tx_word_d = NACK_CMD;
              state_d   = ST_SEND;
            end
          endcase
        end
      end

      ST_GET_ADDR: begin
        if (rx_valid) begin
          tmo_d   = '0;
          base_d  = rx_word[ADDR_W-1:0];
          state_d = ST_GET_LEN;
        end
      end

      ST_GET_LEN: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (len_bad) begin
            tx_word_d = NACK_LEN;
            state_d   = ST_SEND;
          end else begin
            len_d   = rx_word[ADDR_W:0];
            idx_d   = '0;
            csum_d  = '0;
            state_d = ST_GET_DATA;
          end
        end
      end

      ST_GET_DATA: begin
        if (rx_valid) begin
          tmo_d       = '0;
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + idx_q[ADDR_W-1:0];
          mem_wdata_d = rx_word;
          csum_d      = csum_inc;
          idx_d       = idx_inc;
          if (idx_inc == len_q) begin
            tx_word_d = csum_inc;
            state_d   = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        // Incoming words are ignored here, even in the tx_done cycle.
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-word idle timer for the load phases; a received word always wins.
    if (in_load && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign tx_word     = tx_word_q;
  assign tx_req      = (state_q == ST_SEND);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign core_run    = core_run_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - scoreboard bench for boot_loader_ctrl with randomized transactions
module tb_boot_loader_ctrl;
  localparam int ADDR_W = 10;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       rx_word;
  logic              rx_valid;
  logic [31:0]       tx_word;
  logic              tx_req;
  logic              tx_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              core_run;
  logic              busy;
  logic              err_timeout;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid),
    .tx_word(tx_word), .tx_req(tx_req), .tx_done(tx_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .core_run(core_run), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_count = 0;
  logic [31:0]       exp_tx[$];
  logic [ADDR_W-1:0] exp_waddr[$];
  logic [31:0]       exp_wdata[$];
  logic [31:0]       dir_data[$];
  bit                model_run = 1'b0;
  bit                resp_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: memory writes and responses are popped from the scoreboard queues.
  logic        tx_req_prev = 1'b0;
  logic [31:0] held = '0;
  logic        done_seen = 1'b0;
  always @(posedge clk) done_seen <= tx_done;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_req_prev = 1'b0;
      end else begin
        if (mem_we) begin
          if (exp_waddr.size() == 0) check("unexpected_write", 1, 0);
          else begin
            check("wr_addr", 64'(mem_addr), 64'(exp_waddr.pop_front()));
            check("wr_data", 64'(mem_wdata), 64'(exp_wdata.pop_front()));
          end
        end
        if (tx_req && !tx_req_prev) begin
          held = tx_word;
          if (exp_tx.size() == 0) check("unexpected_tx", 1, 0);
          else check("tx_word", 64'(tx_word), 64'(exp_tx.pop_front()));
        end else if (tx_req && tx_req_prev) begin
          check("tx_word_stable", 64'(tx_word), 64'(held));
        end
        if (done_seen && tx_req_prev) check("tx_req_drop", 64'(tx_req), 0);
        if (err_timeout) err_count++;
        tx_req_prev = tx_req;
      end
    end
  end

  // Responder: completes transmissions after a random delay and sometimes
  // throws a HALT word at the DUT in the tx_done cycle, which must be ignored.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req && resp_en && !rst) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        tx_done = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          rx_word  = 32'hB007_0003;
          rx_valid = 1'b1;
        end
        @(negedge clk);
        tx_done  = 1'b0;
        rx_valid = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_word  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_idle", 64'(busy), 0);
  endtask

  // Non-LOAD commands, plus LOAD while the core runs.
  task automatic cmd(input logic [15:0] op);
    case (op)
      16'h0001: exp_tx.push_back(32'hBAD0_0003);
      16'h0002: begin model_run = 1'b1; exp_tx.push_back(32'hACED_0002); end
      16'h0003: begin model_run = 1'b0; exp_tx.push_back(32'hACED_0003); end
      default:  exp_tx.push_back(32'hBAD0_0001);
    endcase
    send({16'hB007, op});
    check("cmd_resp_latency", 64'(tx_req), 1);
    wait_idle();
    check("core_run", 64'(core_run), 64'(model_run));
  endtask

  // LOAD with the core halted; nsend < n leaves the transaction unfinished.
  task automatic load(input logic [31:0] base_w, input logic [31:0] n, input int nsend);
    logic [ADDR_W-1:0] base;
    logic [31:0]       sum;
    logic [31:0]       d;
    bit                ok;
    base = base_w[ADDR_W-1:0];
    ok = (n != 0) && ((64'(base) + 64'(n)) <= (64'd1 << ADDR_W));
    send(32'hB007_0001);
    send(base_w);
    if (!ok) begin
      exp_tx.push_back(32'hBAD0_0002);
      send(n);
      check("len_nack_latency", 64'(tx_req), 1);
      wait_idle();
    end else begin
      send(n);
      sum = 0;
      for (int i = 0; i < nsend; i++) begin
        d = (dir_data.size() > 0) ? dir_data.pop_front() : $urandom;
        exp_waddr.push_back(base + ADDR_W'(i));
        exp_wdata.push_back(d);
        sum = sum + d;
        if (32'(i) == n - 1) exp_tx.push_back(sum);
        send(d);
      end
      if (32'(nsend) == n) begin
        check("data_resp_latency", 64'(tx_req), 1);
        wait_idle();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {59'd0, tx_req, mem_we, core_run, busy, err_timeout}, 0);
    check({tag, "_data"}, {tx_word, mem_wdata}, 0);
    check({tag, "_addr"}, 64'(mem_addr), 0);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst = 1'b0;
    exp_tx.delete();
    exp_waddr.delete();
    exp_wdata.delete();
    model_run = 1'b0;
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          k;
    rst = 1'b1; rx_valid = 1'b0; rx_word = '0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Garbage is dropped silently; unknown B007 command is NACKed.
    send(32'h1234_5678);
    repeat (5) @(negedge clk);
    check("garbage_busy", {62'd0, busy, tx_req}, 0);
    cmd(16'h00FF);

    // Directed loads: checksum wrap, range boundaries, zero length, upper base bits.
    dir_data.push_back(32'h1); dir_data.push_back(32'h2); dir_data.push_back(32'hFFFF_FFFF);
    load(32'h0000_0010, 3, 3);
    load(32'h0000_03FE, 3, 3);
    load(32'h0000_0040, 0, 0);
    load(32'h0000_03FD, 3, 3);
    load(32'hFFFF_F3FF, 1, 1);

    // RUN / LOAD refused while running / HALT.
    cmd(16'h0002);
    cmd(16'h0001);
    cmd(16'h0003);

    // Random mix of garbage, commands and loads.
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          w = $urandom;
          if (w[31:16] == 16'hB007) w[31:16] = 16'h0;
          send(w);
          repeat (3) @(negedge clk);
          check("rand_garbage_idle", 64'(busy), 0);
        end
        1: begin
          w = $urandom;
          if (w[15:0] == 16'h0001) w[15:0] = 16'h0004;
          cmd($urandom_range(0, 2) == 0 ? w[15:0] : 16'($urandom_range(2, 3)));
        end
        default: begin
          if (model_run) cmd(16'h0001);
          else begin
            w = 32'($urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) load(32'h3FC + 32'($urandom_range(0, 3)), w, int'(w));
            else load($urandom, w, int'(w));
          end
        end
      endcase
    end
    if (model_run) cmd(16'h0003);

    // Timeout: two of four words, then silence.
    load(32'h0000_0100, 4, 2);
    k = 0;
    while (!err_timeout && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("timeout_gap", 64'(k), 64'(TMO));
    check("timeout_idle", 64'(busy), 0);
    @(negedge clk);
    check("timeout_pulse_width", 64'(err_timeout), 0);
    check("timeout_writes_left", 64'(exp_waddr.size()), 0);

    // Reset mid-load, then a normal RUN/HALT.
    load(32'h0000_0020, 4, 2);
    rst_pulse("rst_data");
    cmd(16'h0002);
    cmd(16'h0003);

    // Reset mid-response, then a normal RUN.
    resp_en = 1'b0;
    exp_tx.push_back(32'hACED_0002);
    send(32'hB007_0002);
    repeat (3) @(negedge clk);
    check("send_hold", {62'd0, tx_req, core_run}, 3);
    rst_pulse("rst_send");
    resp_en = 1'b1;
    cmd(16'h0002);
    cmd(16'h0003);

    repeat (5) @(negedge clk);
    check("tx_queue_empty", 64'(exp_tx.size()), 0);
    check("wr_queue_empty", 64'(exp_waddr.size()), 0);
    check("err_timeout_count", 64'(err_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
